// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small write queue in front of the shifter.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 8000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    wdata,
    input  logic                          wvalid,
    output logic                          wready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_next;
    logic        busy_q;

    logic        push, pop, empty;
    logic [7:0]  head;

    assign push = wvalid && wready;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] count_q;

    assign head       = mem_q[rptr_q];
    assign empty      = (count_q == '0);
    assign wready     = (count_q != CW'(FIFO_DEPTH));
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_full_q;

    assign head       = hold_q;
    assign empty      = !hold_full_q;
    assign wready     = !hold_full_q;
    assign fifo_count = CW'(hold_full_q);

    // push needs an empty register and pop a full one, so they never coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_q      <= 8'h00;
        end else if (push) begin
            hold_full_q <= 1'b1;
            hold_q      <= wdata;
        end else if (pop) begin
            hold_full_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_next = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = BAUD_RELOAD;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_next = 1'b0;
                if (baud_q == 16'd0) begin
                    baud_d  = BAUD_RELOAD;
                    idx_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StData: begin
                tx_next = shift_q[0];
                if (baud_q == 16'd0) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            StStop: begin
                if (baud_q == 16'd0) begin
                    if (!empty) begin
                        // next frame starts straight after the stop bit
                        pop     = 1'b1;
                        shift_d = head;
                        baud_d  = BAUD_RELOAD;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // tx and busy are registered from the current state, so both lag it by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_next;
            busy_q  <= (state_q != StIdle) || !empty;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance at 16 cycles/bit, one at 1000 cycles/bit.
// Expected values follow the build: UART_TX_FIFO_EN selects queue depth 4, otherwise 1.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH_EFF = 4;
`else
    localparam int DEPTH_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wdata_a, wdata_b;
    logic       wvalid_a, wvalid_b;
    logic       wready_a, wready_b;
    logic       tx_a, tx_b, busy_a, busy_b;
    logic [2:0] fifo_count_a, fifo_count_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int maxcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_DIV(16), .FIFO_DEPTH(4)) u_a (
        .clk        (clk),
        .reset      (reset),
        .wdata      (wdata_a),
        .wvalid     (wvalid_a),
        .wready     (wready_a),
        .tx         (tx_a),
        .busy       (busy_a),
        .fifo_count (fifo_count_a)
    );

    uart_tx_fifo #(.CLK_DIV(1000), .FIFO_DEPTH(4)) u_b (
        .clk        (clk),
        .reset      (reset),
        .wdata      (wdata_b),
        .wvalid     (wvalid_b),
        .wready     (wready_b),
        .tx         (tx_b),
        .busy       (busy_b),
        .fifo_count (fifo_count_b)
    );

    function automatic logic tx_sel(input bit big);
        return big ? tx_b : tx_a;
    endfunction

    // Drive wvalid on instance a for up to n_cyc cycles or until n_acc bytes are taken.
    task automatic push_a(input int n_acc, input int n_cyc, input logic [7:0] first,
                          output int e, output int nacc);
        logic acc;
        nacc = 0;
        e = -1;
        for (int i = 0; i < n_cyc && nacc < n_acc; i++) begin
            @(negedge clk);
            wvalid_a = 1'b1;
            wdata_a  = first + 8'(nacc);
            acc      = wready_a;
            if (int'(fifo_count_a) > maxcnt) maxcnt = int'(fifo_count_a);
            if (acc && e < 0) e = cyc + 1;
            @(posedge clk);
            if (acc) nacc++;
        end
        #1 wvalid_a = 1'b0;
    endtask

    task automatic wait_until(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    // Sample mid-bit after a falling edge; ok=0 on timeout or framing error.
    task automatic uart_rx(input bit big, output logic [7:0] b, output bit ok);
        int div = big ? 1000 : 16;
        int n = 0;
        ok = 1'b0;
        b  = 8'h00;
        @(negedge clk);
        while (tx_sel(big) !== 1'b0 && n < div * 12) begin
            @(negedge clk);
            n++;
        end
        if (tx_sel(big) !== 1'b0) return;
        repeat (div / 2) @(negedge clk);
        if (tx_sel(big) !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = tx_sel(big);
        end
        repeat (div) @(negedge clk);
        if (tx_sel(big) !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (tx_a !== 1'b1 || wready_a !== 1'b1 || busy_a !== 1'b0 || fifo_count_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_a: tx=%b wready=%b busy=%b count=%0d required 1 1 0 0",
                     tx_a, wready_a, busy_a, fifo_count_a);
        end
        checks++;
        if (tx_b !== 1'b1 || wready_b !== 1'b1 || busy_b !== 1'b0 || fifo_count_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_b: tx=%b wready=%b busy=%b count=%0d required 1 1 0 0",
                     tx_b, wready_b, busy_b, fifo_count_b);
        end
    endtask

    task automatic test_single_frame;
        int e, n;
        logic [7:0] v = 8'hA5;
        logic exp;
        push_a(1, 4, v, e, n);
        for (int k = 1; k <= 162; k++) begin
            wait_until(e + k);
            if (k == 1 || k >= 146)      exp = 1'b1;
            else if (k <= 17)            exp = 1'b0;
            else                         exp = v[(k - 18) / 16];
            checks++;
            if (tx_a !== exp) begin
                errors++;
                $display("FAIL a5_tx k=%0d: tx=%b required %b", k, tx_a, exp);
            end
            if (k == 1 || k == 161 || k == 162) begin
                checks++;
                if (busy_a !== (k != 162)) begin
                    errors++;
                    $display("FAIL a5_busy k=%0d: busy=%b required %b", k, busy_a, k != 162);
                end
            end
        end
    endtask

    task automatic test_burst;
        int e, n;
        logic [7:0] b;
        bit ok;
        maxcnt = 0;
        fork
            push_a(99, 6, 8'h00, e, n);
            begin
                for (int i = 0; i < DEPTH_EFF + 1; i++) begin
                    uart_rx(1'b0, b, ok);
                    checks++;
                    if (!ok || b !== 8'(i)) begin
                        errors++;
                        $display("FAIL burst_byte%0d: got %h ok=%b required %h", i, b, ok, 8'(i));
                    end
                end
            end
        join
        checks++;
        if (n != DEPTH_EFF + 1) begin
            errors++;
            $display("FAIL burst_accepts: %0d required %0d", n, DEPTH_EFF + 1);
        end
        checks++;
        if (maxcnt != DEPTH_EFF) begin
            errors++;
            $display("FAIL burst_maxcount: %0d required %0d", maxcnt, DEPTH_EFF);
        end
        @(negedge clk);
        while (busy_a === 1'b1 && cyc < e + 2000) @(negedge clk);
        checks++;
        if (cyc != e + 2 + 160 * (DEPTH_EFF + 1)) begin
            errors++;
            $display("FAIL burst_length: busy fell at +%0d required +%0d",
                     cyc - e, 2 + 160 * (DEPTH_EFF + 1));
        end
    endtask

    task automatic test_back_to_back;
        int e, n;
        logic [7:0] b;
        bit ok;
        push_a(DEPTH_EFF + 1, 20, 8'h10, e, n);
        checks++;
        if (n != DEPTH_EFF + 1) begin
            errors++;
            $display("FAIL fill_accepts: %0d required %0d", n, DEPTH_EFF + 1);
        end
        wait_until(e + 160);
        wvalid_a = 1'b1;
        wdata_a  = 8'h10 + 8'(DEPTH_EFF + 1);
        checks++;
        if (wready_a !== 1'b0) begin
            errors++;
            $display("FAIL pop_edge_refused: wready=%b required 0", wready_a);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wready_a !== 1'b1 || int'(fifo_count_a) != DEPTH_EFF - 1) begin
            errors++;
            $display("FAIL after_pop: wready=%b count=%0d required 1 %0d",
                     wready_a, fifo_count_a, DEPTH_EFF - 1);
        end
        @(posedge clk);
        #1 wvalid_a = 1'b0;
        checks++;
        if (int'(fifo_count_a) != DEPTH_EFF) begin
            errors++;
            $display("FAIL next_accept: count=%0d required %0d", fifo_count_a, DEPTH_EFF);
        end
        for (int i = 0; i < DEPTH_EFF + 1; i++) begin
            uart_rx(1'b0, b, ok);
            checks++;
            if (!ok || b !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL order_byte%0d: got %h ok=%b required %h", i, b, ok, 8'h11 + 8'(i));
            end
        end
        n = 0;
        while (busy_a === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset_mid_frame;
        int e, n, q;
        bit quiet = 1'b1;
        q = (DEPTH_EFF >= 2) ? 2 : 1;
        push_a(1, 4, 8'hFF, e, n);
        push_a(q, 20, 8'h01, n, n);
        wait_until(e + 72);
        reset    = 1'b1;
        wvalid_a = 1'b1;
        wdata_a  = 8'h55;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wvalid_a = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_count_a !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b count=%0d required 1 0 0",
                     tx_a, busy_a, fifo_count_a);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_count_a !== 3'd0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL post_reset_quiet: activity seen, required idle line");
        end
    endtask

    task automatic test_string;
        logic [7:0] str [3];
        str[0] = 8'h4F;
        str[1] = 8'h4B;
        str[2] = 8'h0A;
        fork
            begin
                int n;
                for (int i = 0; i < 3; i++) begin
                    n = 0;
                    @(negedge clk);
                    while (wready_b !== 1'b1 && n < 30000) begin
                        @(negedge clk);
                        n++;
                    end
                    wvalid_b = 1'b1;
                    wdata_b  = str[i];
                    @(posedge clk);
                    #1 wvalid_b = 1'b0;
                end
            end
            begin
                logic [7:0] b;
                bit ok;
                for (int i = 0; i < 3; i++) begin
                    uart_rx(1'b1, b, ok);
                    checks++;
                    if (!ok || b !== str[i]) begin
                        errors++;
                        $display("FAIL string_byte%0d: got %h ok=%b required %h", i, b, ok, str[i]);
                    end
                end
            end
        join
    endtask

    initial begin
        reset    = 1'b1;
        wvalid_a = 1'b0;
        wvalid_b = 1'b0;
        wdata_a  = 8'h00;
        wdata_b  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset;
        test_single_frame;
        test_burst;
        test_back_to_back;
        test_reset_mid_frame;
        test_string;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
